// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch control between the PC register,
// instruction memory and the decoder.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   pc_in               current PC from the PC register
//   next_pc, pc_change  PC load value / load enable (combinational)
//   imem_req/imem_addr  instruction-memory read request and address
//   imem_ack/imem_rdata memory read-data valid and data
//   ir_valid/ir_data/ir_pc  latched instruction presented to decode
//   ir_ready            decode consumes ir_data this cycle
//   redirect/redirect_target  taken branch or jump from decode
//   halt                decode executed HALT
//   halted              sticky halted status
module fetch_sequencer #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_in,
    output logic [ADDR_W-1:0] next_pc,
    output logic              pc_change,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              ir_valid,
    output logic [DATA_W-1:0] ir_data,
    output logic [ADDR_W-1:0] ir_pc,
    input  logic              ir_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_target,
    input  logic              halt,
    output logic              halted
);

    typedef enum logic [2:0] {
        ST_START,
        ST_FETCH,
        ST_HOLD,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    state_t            r_state;
    logic              r_imem_req;
    logic              r_ir_valid;
    logic [DATA_W-1:0] r_ir_data;
    logic [ADDR_W-1:0] r_ir_pc;
    logic              r_halted;

    logic              w_pc_change;
    logic [ADDR_W-1:0] w_next_pc;
    logic              w_halt_now;

    // halt is only honoured once the sequencer has left START
    assign w_halt_now = halt && (r_state != ST_START);

    // PC update: halt suppresses everything, redirect beats sequential advance
    always_comb begin
        w_pc_change = 1'b0;
        w_next_pc   = '0;
        if (!w_halt_now) begin
            case (r_state)
                ST_FETCH, ST_DRAIN: begin
                    if (redirect) begin
                        w_pc_change = 1'b1;
                        w_next_pc   = redirect_target;
                    end
                end
                ST_HOLD: begin
                    if (redirect) begin
                        w_pc_change = 1'b1;
                        w_next_pc   = redirect_target;
                    end else if (ir_ready) begin
                        w_pc_change = 1'b1;
                        w_next_pc   = pc_in + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_START;
            r_imem_req <= 1'b0;
            r_ir_valid <= 1'b0;
            r_ir_data  <= '0;
            r_ir_pc    <= '0;
            r_halted   <= 1'b0;
        end else if (w_halt_now) begin
            r_state    <= ST_HALTED;
            r_halted   <= 1'b1;
            r_imem_req <= 1'b0;
            r_ir_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_START: begin
                    r_state    <= ST_FETCH;
                    r_imem_req <= 1'b1;
                end
                ST_FETCH: begin
                    if (redirect) begin
                        r_ir_valid <= 1'b0;
                        // an ack arriving with the redirect is dropped; without
                        // one the request is still in flight and must be drained
                        if (!imem_ack) begin
                            r_state    <= ST_DRAIN;
                            r_imem_req <= 1'b0;
                        end
                    end else if (imem_ack) begin
                        r_ir_data  <= imem_rdata;
                        r_ir_pc    <= pc_in;
                        r_ir_valid <= 1'b1;
                        r_imem_req <= 1'b0;
                        r_state    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (redirect || ir_ready) begin
                        r_ir_valid <= 1'b0;
                        r_imem_req <= 1'b1;
                        r_state    <= ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    // stale data is discarded; PC may have been redirected again
                    if (imem_ack) begin
                        r_imem_req <= 1'b1;
                        r_state    <= ST_FETCH;
                    end
                end
                ST_HALTED: ;
                default: r_state <= ST_START;
            endcase
        end
    end

    assign next_pc   = w_next_pc;
    assign pc_change = w_pc_change;
    assign imem_req  = r_imem_req;
    assign imem_addr = pc_in;
    assign ir_valid  = r_ir_valid;
    assign ir_data   = r_ir_data;
    assign ir_pc     = r_ir_pc;
    assign halted    = r_halted;

endmodule
